// File: rtl/timer_pkg.sv
// ============================================================================
//  Module      : timer_pkg
//  Description : Register map and reset constants shared by the machine
//                timer block (timer_cmp and its sub-modules).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  // Register-port address map (3-bit select)
  localparam logic [2:0] TIMER_MTIME_LO    = 3'd0;
  localparam logic [2:0] TIMER_MTIME_HI    = 3'd1;
  localparam logic [2:0] TIMER_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] TIMER_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] TIMER_PRESCALE    = 3'd4;

  // mtimecmp resets to all ones so no interrupt fires until software programs it.
  // Wide enough for any XLEN up to 64; the top slices what it needs.
  localparam logic [127:0] TIMER_MTIMECMP_RESET = '1;

endpackage : timer_pkg

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
//  Module      : timer_prescaler
//  Description : Programmable divider for the machine timer. Counts 0..N and
//                strobes tick_o when the count equals N, so the timer advances
//                every N+1 cycles (N=0 -> every cycle). Writing N restarts the
//                count from zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_i,
  input  logic [PRESCALE_W-1:0] wd_i,
  output logic [PRESCALE_W-1:0] div_o,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [PRESCALE_W-1:0] count_q, count_d;

  assign tick_o = (count_q == div_q);
  assign div_o  = div_q;

  // Next divider/count: a write reloads N and restarts; otherwise wrap at N
  always_comb begin
    div_d   = div_q;
    count_d = count_q + 1'b1;
    if (wr_i) begin
      div_d   = wd_i;
      count_d = '0;
    end else if (tick_o) begin
      count_d = '0;
    end
  end

  // Divider and count state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      count_q <= '0;
    end else begin
      div_q   <= div_d;
      count_q <= count_d;
    end
  end

endmodule : timer_prescaler

`default_nettype wire

// File: rtl/timer_reg.sv
// ============================================================================
//  Module      : timer_reg
//  Description : Enable-gated register with asynchronous active-high reset
//                and a configurable reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_reg #(
  parameter int unsigned   W         = 32,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_q;

  // Load d_i when enabled; reset takes effect immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else if (en_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule : timer_reg

`default_nettype wire

// File: rtl/timer_cmp.sv
// ============================================================================
//  Module      : timer_cmp
//  Description : Machine timer. Free-running 2*XLEN mtime and mtimecmp,
//                accessed as XLEN halves; registered level interrupt when
//                mtime >= mtimecmp. Reading mtime_lo snapshots mtime_hi so a
//                lo-then-hi read pair is coherent.
//                Optional feature macro: TIMER_PRESCALE_EN (adds a
//                programmable tick divider at address 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_cmp
  import timer_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      addr,
  input  logic            we,
  input  logic            re,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd,
  output logic            tick,
  output logic            irq
);

  localparam int unsigned TW = 2 * XLEN;

  logic [TW-1:0]         mtime_q, mtime_d;
  logic [XLEN-1:0]       cmp_lo_q, cmp_hi_q;
  logic [XLEN-1:0]       snap_q;
  logic                  irq_q;
  logic [PRESCALE_W-1:0] w_prescale;
  logic                  w_tick_raw;

  logic w_wr_mtime_lo, w_wr_mtime_hi, w_wr_cmp_lo, w_wr_cmp_hi, w_mtime_en;

  assign w_wr_mtime_lo = we && (addr == TIMER_MTIME_LO);
  assign w_wr_mtime_hi = we && (addr == TIMER_MTIME_HI);
  assign w_wr_cmp_lo   = we && (addr == TIMER_MTIMECMP_LO);
  assign w_wr_cmp_hi   = we && (addr == TIMER_MTIMECMP_HI);

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (we && (addr == TIMER_PRESCALE)),
    .wd_i   (wd[PRESCALE_W-1:0]),
    .div_o  (w_prescale),
    .tick_o (w_tick_raw)
  );
`else
  // No divider: the timer advances every cycle and address 4 reads zero
  assign w_prescale = '0;
  assign w_tick_raw = 1'b1;
`endif

  // Tick is forced low while reset is held
  assign tick = w_tick_raw & ~reset;

  // A software write to either mtime half wins over the tick (that count is dropped)
  assign w_mtime_en = w_wr_mtime_lo | w_wr_mtime_hi | tick;

  // Next mtime: written half replaces, other half holds; else full-width increment
  always_comb begin
    mtime_d = mtime_q + 1'b1;
    if (w_wr_mtime_lo) begin
      mtime_d = {mtime_q[TW-1:XLEN], wd};
    end else if (w_wr_mtime_hi) begin
      mtime_d = {wd, mtime_q[XLEN-1:0]};
    end
  end

  timer_reg #(.W(TW), .RESET_VAL('0)) u_mtime (
    .clk (clk), .reset (reset), .en_i (w_mtime_en), .d_i (mtime_d), .q_o (mtime_q)
  );

  timer_reg #(.W(XLEN), .RESET_VAL(TIMER_MTIMECMP_RESET[XLEN-1:0])) u_cmp_lo (
    .clk (clk), .reset (reset), .en_i (w_wr_cmp_lo), .d_i (wd), .q_o (cmp_lo_q)
  );

  timer_reg #(.W(XLEN), .RESET_VAL(TIMER_MTIMECMP_RESET[TW-1:XLEN])) u_cmp_hi (
    .clk (clk), .reset (reset), .en_i (w_wr_cmp_hi), .d_i (wd), .q_o (cmp_hi_q)
  );

  // Reading mtime_lo captures the upper half as it was in that same cycle
  timer_reg #(.W(XLEN), .RESET_VAL('0)) u_snap (
    .clk (clk), .reset (reset), .en_i (re && (addr == TIMER_MTIME_LO)),
    .d_i (mtime_q[TW-1:XLEN]), .q_o (snap_q)
  );

  // Interrupt level compares registered state, so it trails changes by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (mtime_q >= {cmp_hi_q, cmp_lo_q});
    end
  end

  assign irq = irq_q;

  // Read mux shows live pre-update values; mtime_hi always comes from the snapshot
  always_comb begin
    rd = '0;
    case (addr)
      TIMER_MTIME_LO:    rd = mtime_q[XLEN-1:0];
      TIMER_MTIME_HI:    rd = snap_q;
      TIMER_MTIMECMP_LO: rd = cmp_lo_q;
      TIMER_MTIMECMP_HI: rd = cmp_hi_q;
      TIMER_PRESCALE:    rd = XLEN'(w_prescale);
      default:           rd = '0;
    endcase
  end

endmodule : timer_cmp

`default_nettype wire

// File: tb/tb_timer_cmp.sv
// ============================================================================
//  Module      : tb_timer_cmp
//  Description : Self-checking bench for timer_cmp with a behavioural model
//                (64-bit counter value, cycle phase for the divider).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_cmp;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  addr;
  logic        we, re;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tick, irq;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_snap;
  logic [7:0]  m_n;
  int          m_phase;
  logic        m_irq;

  timer_cmp #(.XLEN(32), .PRESCALE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .re    (re),
    .wd    (wd),
    .rd    (rd),
    .tick  (tick),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  function automatic logic m_tick();
`ifdef TIMER_PRESCALE_EN
    return (m_phase % (int'(m_n) + 1)) == int'(m_n);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_snap;
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
`ifdef TIMER_PRESCALE_EN
      3'd4:    return {24'd0, m_n};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtime = 64'd0; m_cmp = '1; m_snap = 32'd0; m_n = 8'd0; m_phase = 0; m_irq = 1'b0;
  endtask

  // One clock edge of the timer, from the register-level rules
  task automatic model_step(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
    logic t, irq_n;
    t     = m_tick();
    irq_n = (m_mtime >= m_cmp);
    if (r && a == 3'd0) m_snap = m_mtime[63:32];
    if (w && a == 3'd0)      m_mtime[31:0]  = d;
    else if (w && a == 3'd1) m_mtime[63:32] = d;
    else if (t)              m_mtime        = m_mtime + 64'd1;
    if (w && a == 3'd2) m_cmp[31:0]  = d;
    if (w && a == 3'd3) m_cmp[63:32] = d;
`ifdef TIMER_PRESCALE_EN
    if (w && a == 3'd4) begin m_n = d[7:0]; m_phase = 0; end
    else m_phase++;
`endif
    m_irq = irq_n;
  endtask

  // Drive one cycle (starting at a negedge), update the model, return at next negedge
  task automatic do_cycle(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
    we = w; re = r; addr = a; wd = d;
    @(posedge clk);
    model_step(w, r, a, d);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic peek(input logic [2:0] a);
    we = 1'b0; re = 1'b0; addr = a; #1;
  endtask

  task automatic apply_reset();
    we = 1'b0; re = 1'b0; addr = 3'd0; wd = 32'd0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    peek(3'd0);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_lo: got %h want %h", rd, 32'd0); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
    peek(3'd2);
    vectors++; if (rd !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_cmp_lo: got %h want ffffffff", rd); end
    idle(10);
    peek(3'd0);
    vectors++; if (rd !== 32'd10) begin miscompares++; $display("FAIL run10_lo: got %h want %h", rd, 32'd10); end
    do_cycle(1'b0, 1'b1, 3'd0, 32'd0);
    peek(3'd1);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL run10_hi: got %h want 0", rd); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL run10_irq: got %b want 0", irq); end
  endtask

  task automatic test_carry_wrap();
    do_cycle(1'b1, 1'b0, 3'd0, 32'hFFFF_FFFE);
    do_cycle(1'b1, 1'b0, 3'd1, 32'd0);
    idle(2);
    peek(3'd0);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL carry_lo: got %h want 0", rd); end
    do_cycle(1'b0, 1'b1, 3'd0, 32'd0);
    peek(3'd1);
    vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL carry_hi: got %h want 1", rd); end
    do_cycle(1'b1, 1'b0, 3'd1, 32'hFFFF_FFFF);
    do_cycle(1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF);
    idle(1);
    peek(3'd0);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL wrap_lo: got %h want 0", rd); end
    do_cycle(1'b0, 1'b1, 3'd0, 32'd0);
    peek(3'd1);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL wrap_hi: got %h want 0", rd); end
  endtask

  task automatic test_compare();
    int  budget;
    bit  hit;
    apply_reset();
    do_cycle(1'b1, 1'b0, 3'd3, 32'd0);
    do_cycle(1'b1, 1'b0, 3'd2, 32'd20);
    hit = 1'b0;
    for (budget = 0; budget < 40 && !hit; budget++) begin
      peek(3'd0);
      if (rd == 32'd20) hit = 1'b1;
      else idle(1);
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL cmp_reach20: got timeout want mtime=20"); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL cmp_irq_at20: got %b want 0", irq); end
    idle(1);
    peek(3'd0);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL cmp_irq_rise: got %b want 1", irq); end
    vectors++; if (rd !== 32'd21) begin miscompares++; $display("FAIL cmp_rise_time: got %h want %h", rd, 32'd21); end
    do_cycle(1'b1, 1'b0, 3'd2, 32'd100);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL cmp_irq_hold: got %b want 1", irq); end
    idle(1);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL cmp_irq_fall: got %b want 0", irq); end
  endtask

  task automatic test_write_wins();
    do_cycle(1'b1, 1'b0, 3'd1, 32'd7);
    we = 1'b1; re = 1'b0; addr = 3'd0; wd = 32'd5; #1;
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL wr_tick: got %b want 1", tick); end
    do_cycle(1'b1, 1'b0, 3'd0, 32'd5);
    peek(3'd0);
    vectors++; if (rd !== 32'd5) begin miscompares++; $display("FAIL wr_lo: got %h want 5", rd); end
    do_cycle(1'b0, 1'b1, 3'd0, 32'd0);
    peek(3'd1);
    vectors++; if (rd !== 32'd7) begin miscompares++; $display("FAIL wr_hi_hold: got %h want 7", rd); end
  endtask

  task automatic test_snapshot();
    do_cycle(1'b1, 1'b0, 3'd1, 32'd0);
    do_cycle(1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF);
    we = 1'b0; re = 1'b1; addr = 3'd0; #1;
    vectors++; if (rd !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL snap_lo: got %h want ffffffff", rd); end
    do_cycle(1'b0, 1'b1, 3'd0, 32'd0);
    peek(3'd1);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL snap_hi: got %h want 0", rd); end
  endtask

  task automatic test_prescale();
    logic [31:0] start;
    apply_reset();
    do_cycle(1'b1, 1'b0, 3'd4, 32'd3);
    peek(3'd4);
`ifdef TIMER_PRESCALE_EN
    vectors++; if (rd !== 32'd3) begin miscompares++; $display("FAIL presc_rd: got %h want 3", rd); end
`else
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL presc_rd: got %h want 0", rd); end
`endif
    peek(3'd0);
    start = rd;
    idle(40);
    peek(3'd0);
`ifdef TIMER_PRESCALE_EN
    vectors++; if (rd !== start + 32'd10) begin miscompares++; $display("FAIL presc_count: got %h want %h", rd, start + 32'd10); end
`else
    vectors++; if (rd !== start + 32'd40) begin miscompares++; $display("FAIL presc_count: got %h want %h", rd, start + 32'd40); end
`endif
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_cycle(1'b1, 1'b0, 3'd3, 32'd0);
    do_cycle(1'b1, 1'b0, 3'd2, 32'd0);
    idle(3);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL areset_pre_irq: got %b want 1", irq); end
    addr = 3'd0; #2;
    reset = 1'b1; #1;
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL areset_lo: got %h want 0", rd); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL areset_irq: got %b want 0", irq); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL areset_tick: got %b want 0", tick); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic        w, r;
    logic [2:0]  a;
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      a = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 1) == 1;
      case (a)
        3'd1, 3'd3: d = 32'($urandom_range(0, 1));
        3'd4:       d = 32'($urandom_range(0, 3));
        default:    d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 300)) : $urandom;
      endcase
      we = w; re = r; addr = a; wd = d; #1;
      vectors++; if (rd !== m_rd(a)) begin miscompares++; $display("FAIL rnd_rd[%0d] addr %0d: got %h want %h", i, a, rd, m_rd(a)); end
      vectors++; if (tick !== m_tick()) begin miscompares++; $display("FAIL rnd_tick[%0d]: got %b want %b", i, tick, m_tick()); end
      @(posedge clk);
      model_step(w, r, a, d);
      @(negedge clk);
      we = 1'b0; re = 1'b0;
      vectors++; if (irq !== m_irq) begin miscompares++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq, m_irq); end
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = 3'd0; wd = 32'd0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_carry_wrap();
    test_compare();
    test_write_wins();
    test_snapshot();
    test_prescale();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_timer_cmp

`default_nettype wire
